uart_fifo_tx: RTL

UART transmitter that drains the synchronous byte FIFO from its read port and serializes each byte onto a TX line as 8N1/8E1/8O1/8N2 frames. It is the consumer on the FIFO's read port: it issues single-cycle pops, takes the data on the FIFO's registered read port one cycle later, and shifts the data out at a fixed bit period. It sits between the CPU-facing TX FIFO and the board UART pin.

---
 rtl/uart_fifo_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//   UART transmitter that drains a synchronous byte FIFO through its read
//   port and serializes each byte as a start bit, 8 data bits (LSB first),
//   an optional parity bit and 1 or 2 stop bits.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
//
// Ports
//   clk_i               system clock, rising edge
//   reset_i             asynchronous reset, active low
//   tx_enable_i         allows a new frame to start (sampled in IDLE only)
//   fifo_empty_i        FIFO empty flag
//   fifo_read_enable_o  single-cycle pop request
//   fifo_read_data_i    FIFO read data, valid with fifo_read_valid_i
//   fifo_read_valid_i   read-data valid, one cycle after the pop
//   tx_o                registered serial output, idles high
//   busy_o              high whenever the FSM is not in IDLE
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tx_enable_i,
  input  logic       fifo_empty_i,
  output logic       fifo_read_enable_o,
  input  logic [7:0] fifo_read_data_i,
  input  logic       fifo_read_valid_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            w_tick;
  logic            w_pop;

  assign w_tick = (r_baud == BAUD_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and pop request. The pop is gated by reset_i directly so it
  // drops the instant reset asserts, not only after the state register clears.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = tx_enable_i && !fifo_empty_i && reset_i;
        if (w_pop) w_next = S_WAIT;
      end
      // No data means the empty flag lagged the last pop; drop back quietly.
      S_WAIT:   w_next = fifo_read_valid_i ? S_START : S_IDLE;
      S_START:  if (w_tick) w_next = S_DATA;
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && r_bit == STOP_LAST) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath. r_tx is loaded with the value of the bit about to begin, so
  // the line changes exactly on the bit boundary edge. r_bit counts data bits
  // and is reused as the stop-bit counter (it wraps 7 -> 0 leaving DATA).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: r_tx <= 1'b1;
        S_WAIT: begin
          if (fifo_read_valid_i) begin
            r_shift <= fifo_read_data_i;
            r_par   <= (PARITY == 2) ? ~^fifo_read_data_i : ^fifo_read_data_i;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_baud <= '0;
            r_tx   <= r_shift[0];
          end else r_baud <= r_baud + CW'(1);
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) r_tx <= (PARITY != 0) ? r_par : 1'b1;
            else               r_tx <= r_shift[1];
          end else r_baud <= r_baud + CW'(1);
        end
        S_PARITY: begin
          if (w_tick) begin
            r_baud <= '0;
            r_tx   <= 1'b1;
          end else r_baud <= r_baud + CW'(1);
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud <= '0;
            r_bit  <= r_bit + 3'd1;
          end else r_baud <= r_baud + CW'(1);
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign fifo_read_enable_o = w_pop;
  assign tx_o               = r_tx;
  assign busy_o             = (r_state != S_IDLE);

endmodule
